lmg_move_drain: RTL
===================

# lmg_move_drain

Drains the LMG output FIFO and serialises its packed move words into a stream of single 19-bit moves for the downstream search/evaluation stage. Each 160-bit FIFO word carries up to eight move slots. Empty (all-zero) slots are skipped. The block also counts emitted moves and flags the end of the list once the LMG has finished and its FIFO is drained.

## Interface
Parameters
- MOVE_W, 19: width of one move slot.
- SLOTS, 8: move slots per FIFO word.
- WORD_W, 160: FIFO word width.

Ports
- clk, in, 1: single clock, rising edge.
- reset, in, 1: synchronous, active-high.
- start, in, 1: one-cycle pulse; begin draining a new move list. Only accepted in IDLE or DONE.
- lmg_done, in, 1: LMG `done`; high once generation is complete.
- fifo_empty, in, 1: LMG `fifoEmpty`.
- fifo_out, in, 160: LMG `fifoOut`.
- rden, out, 1: LMG FIFO read enable. Single-cycle pulses only.
- mv_out, out, 19: current move.
- mv_valid, out, 1: mv_out holds a move.
- mv_ready, in, 1: consumer accepts the move when mv_valid & mv_ready.
- mv_count, out, 8: moves accepted since the last start; saturates at 255.
- list_done, out, 1: level signal; list fully delivered. Held until the next accepted start.

## Operation
- Slot k (k = 1..8) occupies fifo_out[151-19(k-1) -: 19]. Slot 1 is bits [151:133] and slot 8 is bits [18:0]. Bits [159:152] are ignored.
- A slot equal to 19'd0 is a null slot and is never emitted. Move contents are otherwise opaque to this block.
- Emission order is slot 1 to slot 8 within a word, and words are emitted in FIFO order.
- States:
  - IDLE: on start, go to WAIT and clear mv_count.
  - WAIT:
    - If !fifo_empty: pulse rden and go to RDLAT.
    - Else if lmg_done: go to DONE.
  - RDLAT: no action. FIFO data is valid on the cycle after rden (non-show-ahead). Go to LOAD.
  - LOAD: latch slots 1–8 into a 152-bit buffer and set mask[k] = (slot k != 0). Go to EMIT.
  - EMIT:
    - mv_out is the lowest-index slot with mask set; mv_valid = 1.
    - On handshake: clear that mask bit and increment mv_count.
    - When the mask becomes empty (or is empty on entry), go to WAIT.
  - DONE: list_done = 1. On start, go to WAIT, clear mv_count and deassert list_done.
- Completion condition: lmg_done & fifo_empty must be seen in WAIT, with the buffer empty.
- start is ignored in WAIT, RDLAT, LOAD and EMIT.

## Timing
- Reset values: rden=0, mv_valid=0, mv_out=0, mv_count=0, list_done=0, state=IDLE, mask=0.
- All outputs are registered.
- mv_out is stable while mv_valid & !mv_ready.
- Latency from FIFO non-empty observed in WAIT to the first mv_valid: 3 cycles (rden, RDLAT, LOAD).
- Throughput: one move per cycle while mv_ready is held high. The next move is presented in the cycle after each handshake, with no bubble inside a word.
- Word-to-word gap: a 3-cycle bubble, through the WAIT, RDLAT and LOAD states.
- A word with all slots null passes LOAD and EMIT in one cycle each and emits nothing.
- An all-null word still costs a FIFO read.
- rden is never asserted while fifo_empty = 1.
- There is at most one outstanding read.
- mv_count saturates at 255. Legal move lists never exceed 218, so saturation is a safety measure only.
- Reset mid-operation returns to IDLE immediately. Any buffered word is discarded and the FIFO is not read further.

## Structure
- Shared package chess_pkg holds:
  - MOVE_W, SLOTS, WORD_W.
  - The slot offset function slot_lsb(k).
  - The drain state enum (IDLE, WAIT, RDLAT, LOAD, EMIT, DONE).
  - NULL_MOVE = 19'd0.
- One sub-module, slot_pick: 8-bit mask in; 3-bit index of the lowest set bit and an `any` flag out (combinational priority encoder).
- The top level holds the FSM, the slot buffer, the mask, the counter and the output registers.

## Test plan
- Single word, slots 1–3 = 19'h00001, 19'h00002, 19'h00003 and the rest null; mv_ready=1; lmg_done=1 → exactly 3 moves in order, mv_count=3, list_done=1, exactly one rden pulse.
- Two full words (16 non-null moves), mv_ready=1 → 16 moves in order, a 3-cycle gap between words, mv_count=16.
- Backpressure: mv_ready toggled 1,0,0,1,… during a word → mv_out held constant while stalled, no move lost or duplicated.
- Word with slots 2, 5 and 8 non-null, all others 0 → only those 3 emitted, in slot order.
- lmg_done rises while FIFO already empty, no words → list_done asserted 1 cycle after start acceptance + WAIT, mv_count=0, rden never asserted.
- reset asserted mid-EMIT → next cycle mv_valid=0, mv_count=0, state IDLE; start pulses during EMIT ignored.

Source files
------------

// File: rtl/chess_pkg.sv
// Shared move-list types and constants for the LMG output drain.
package chess_pkg;

  localparam int unsigned MOVE_W = 19;
  localparam int unsigned SLOTS  = 8;
  localparam int unsigned WORD_W = 160;
  localparam int unsigned IDX_W  = $clog2(SLOTS);

  localparam logic [MOVE_W-1:0] NULL_MOVE = '0;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    RDLAT,
    LOAD,
    EMIT,
    DONE
  } drain_state_t;

  // Slot k (1..8) sits at [lsb +: MOVE_W]; slot 1 is the most significant.
  function automatic int unsigned slot_lsb(input int unsigned k);
    return SLOTS * MOVE_W - MOVE_W * k;
  endfunction

endpackage

// File: rtl/slot_pick.sv
// Priority encoder: index of the lowest set mask bit plus an any-set flag.
module slot_pick
  import chess_pkg::*;
(
  input  logic [SLOTS-1:0] mask,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    idx = '0;
    any = |mask;
    // Scan from the top so the lowest set bit is the last one written.
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (mask[SLOTS-1-i]) idx = IDX_W'(SLOTS - 1 - i);
    end
  end

endmodule

// File: rtl/lmg_move_drain.sv
// Drains packed LMG FIFO words and serialises non-null move slots into a
// ready/valid stream, counting moves and flagging list completion.
module lmg_move_drain #(
  parameter int unsigned MOVE_W = 19,
  parameter int unsigned SLOTS  = 8,
  parameter int unsigned WORD_W = 160
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              lmg_done,
  input  logic              fifo_empty,
  input  logic [WORD_W-1:0] fifo_out,
  output logic              rden,
  output logic [MOVE_W-1:0] mv_out,
  output logic              mv_valid,
  input  logic              mv_ready,
  output logic [7:0]        mv_count,
  output logic              list_done
);

  import chess_pkg::*;

  drain_state_t      state, stateNext;
  logic [MOVE_W-1:0] slotBuf     [SLOTS];
  logic [MOVE_W-1:0] slotBufNext [SLOTS];
  logic [SLOTS-1:0]  mask, maskNext;
  logic [IDX_W-1:0]  curIdx, outIdx;
  logic              curAny, outAny;
  logic [7:0]        countNext;
  logic              rdenNext, validNext, listDoneNext;
  logic [MOVE_W-1:0] outNext;
  logic              handshake;
  logic              unusedHeader;

  assign handshake    = mv_valid & mv_ready;
  assign unusedHeader = ^fifo_out[WORD_W-1:SLOTS*MOVE_W];

  slot_pick uPickCur (.mask(mask),     .idx(curIdx), .any(curAny));
  slot_pick uPickOut (.mask(maskNext), .idx(outIdx), .any(outAny));

  always_comb begin
    stateNext   = state;
    maskNext    = mask;
    slotBufNext = slotBuf;
    countNext   = mv_count;
    rdenNext    = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          stateNext = WAIT;
          countNext = '0;
        end
      end
      WAIT: begin
        if (!fifo_empty) begin
          rdenNext  = 1'b1;
          stateNext = RDLAT;
        end else if (lmg_done) begin
          stateNext = DONE;
        end
      end
      RDLAT: stateNext = LOAD;
      LOAD: begin
        for (int unsigned i = 0; i < SLOTS; i++) begin
          slotBufNext[i] = fifo_out[slot_lsb(i + 1) +: MOVE_W];
          maskNext[i]    = (slotBufNext[i] != NULL_MOVE);
        end
        stateNext = EMIT;
      end
      EMIT: begin
        if (handshake && curAny) begin
          maskNext[curIdx] = 1'b0;
          if (mv_count != 8'hFF) countNext = mv_count + 8'd1;
        end
        if (maskNext == '0) stateNext = WAIT;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Outputs are registered from next-cycle state, so the move is
  // looked up from the post-handshake mask.
  always_comb begin
    validNext    = (stateNext == EMIT) && outAny;
    outNext      = validNext ? slotBufNext[outIdx] : mv_out;
    listDoneNext = (stateNext == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mask      <= '0;
      for (int unsigned i = 0; i < SLOTS; i++) slotBuf[i] <= '0;
      rden      <= 1'b0;
      mv_valid  <= 1'b0;
      mv_out    <= '0;
      mv_count  <= '0;
      list_done <= 1'b0;
    end else begin
      state     <= stateNext;
      mask      <= maskNext;
      slotBuf   <= slotBufNext;
      rden      <= rdenNext;
      mv_valid  <= validNext;
      mv_out    <= outNext;
      mv_count  <= countNext;
      list_done <= listDoneNext;
    end
  end

endmodule
